glb_wr_bank: RTL and testbench

Single-bank circular buffer on one ITF write port of the global buffer (GLB). It accepts SRAM-width words from ITF under a valid/ready handshake and tracks a CCU-programmed transfer length. It reports full to ITF so that ITF releases the pad bus and re-arbitrates. It streams stored words in order to the compute-core consumer through a 1-cycle-latency SRAM array and a 2-entry output buffer.

---
 rtl/glb_wr_bank.sv | 141 ++++++++++++++
 tb/tb_glb_wr_bank.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_wr_bank.sv
// glb_wr_bank: single-bank circular write buffer between one ITF write port
// and a compute-core consumer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   CCUGLB_Rst            sync clear of pointers, counters, OB, error flag
//   CCUGLB_CfgVld/WrNum   latch transfer length, restart WrCnt
//   ITFGLB_WrAddr/WrDat/WrDatVld, GLBITF_WrDatRdy   write handshake
//   GLBITF_WrFull         bank full or transfer complete
//   GLBCOR_RdDat/RdDatVld, CORGLB_RdDatRdy          read handshake
//   GLBCCU_Done           transfer written and bank drained
//   GLBCCU_AddrErr        sticky ITF address mismatch
module glb_wr_bank #(
    parameter int SRAM_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  CCUGLB_Rst,
    input  logic                  CCUGLB_CfgVld,
    input  logic [ADDR_WIDTH-1:0] CCUGLB_WrNum,
    input  logic [ADDR_WIDTH-1:0] ITFGLB_WrAddr,
    input  logic [SRAM_WIDTH-1:0] ITFGLB_WrDat,
    input  logic                  ITFGLB_WrDatVld,
    output logic                  GLBITF_WrDatRdy,
    output logic                  GLBITF_WrFull,
    output logic [SRAM_WIDTH-1:0] GLBCOR_RdDat,
    output logic                  GLBCOR_RdDatVld,
    input  logic                  CORGLB_RdDatRdy,
    output logic                  GLBCCU_Done,
    output logic                  GLBCCU_AddrErr
);

    localparam logic [DEPTH_WIDTH:0] OccFull =
        (DEPTH_WIDTH+1)'(1 << DEPTH_WIDTH);

    logic [SRAM_WIDTH-1:0]  mem [1 << DEPTH_WIDTH];
    logic [DEPTH_WIDTH-1:0] wrPtr;
    logic [DEPTH_WIDTH-1:0] rdPtr;
    logic [DEPTH_WIDTH:0]   occ;
    logic [DEPTH_WIDTH:0]   unread;
    logic [ADDR_WIDTH-1:0]  wrCnt;
    logic [ADDR_WIDTH-1:0]  wrNum;
    logic [SRAM_WIDTH-1:0]  ob0;
    logic [SRAM_WIDTH-1:0]  ob1;
    logic [SRAM_WIDTH-1:0]  memRd;
    logic [1:0]             obCnt;
    logic                   addrErr;
    logic                   wrAcc;
    logic                   pop;
    logic                   issue;
    logic                   unusedAddrHi;

    // Only the low address bits are compared against the write pointer.
    assign unusedAddrHi = ^ITFGLB_WrAddr[ADDR_WIDTH-1:DEPTH_WIDTH];

    assign GLBITF_WrDatRdy = (occ < OccFull) && (wrCnt < wrNum);
    assign GLBITF_WrFull   = (occ == OccFull) || (wrCnt >= wrNum);
    assign wrAcc           = ITFGLB_WrDatVld & GLBITF_WrDatRdy;

    assign GLBCOR_RdDatVld = (obCnt != 2'd0);
    assign GLBCOR_RdDat    = GLBCOR_RdDatVld ? ob0 : '0;
    assign pop             = GLBCOR_RdDatVld & CORGLB_RdDatRdy;

    assign GLBCCU_Done     = (wrCnt == wrNum) && (occ == '0);
    assign GLBCCU_AddrErr  = addrErr;

    // Words in the array that have not yet been moved into OB. Uses the
    // registered occupancy, so a word is never read in its write cycle.
    assign unread = occ - {{(DEPTH_WIDTH-1){1'b0}}, obCnt};
    assign issue  = (unread != '0) && (obCnt < 2'd2);
    assign memRd  = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (wrAcc) begin
            mem[wrPtr] <= ITFGLB_WrDat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            occ     <= '0;
            wrCnt   <= '0;
            wrNum   <= '0;
            ob0     <= '0;
            ob1     <= '0;
            obCnt   <= '0;
            addrErr <= 1'b0;
        end else if (CCUGLB_Rst) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            occ     <= '0;
            wrCnt   <= '0;
            wrNum   <= '0;
            ob0     <= '0;
            ob1     <= '0;
            obCnt   <= '0;
            addrErr <= 1'b0;
        end else begin
            if (wrAcc) begin
                wrPtr <= wrPtr + DEPTH_WIDTH'(1);
                if (ITFGLB_WrAddr[DEPTH_WIDTH-1:0] != wrPtr) begin
                    addrErr <= 1'b1;
                end
            end

            // A new configuration restarts the count even if a word is
            // accepted in the same cycle; that word is still stored.
            if (CCUGLB_CfgVld) begin
                wrNum <= CCUGLB_WrNum;
                wrCnt <= '0;
            end else if (wrAcc) begin
                wrCnt <= wrCnt + ADDR_WIDTH'(1);
            end

            if (issue) begin
                rdPtr <= rdPtr + DEPTH_WIDTH'(1);
            end

            occ <= occ + (DEPTH_WIDTH+1)'(wrAcc)
                       - (DEPTH_WIDTH+1)'(pop);

            // OB is a 2-entry queue with head in ob0. The array read lands
            // directly in OB on the edge after issue.
            if (issue && ((obCnt == 2'd0) || (obCnt == 2'd1 && pop))) begin
                ob0 <= memRd;
            end else if (pop) begin
                ob0 <= ob1;
            end
            if (issue && (obCnt == 2'd1) && !pop) begin
                ob1 <= memRd;
            end

            obCnt <= obCnt + 2'(issue) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_glb_wr_bank.sv
// tb_glb_wr_bank: directed bench for glb_wr_bank with a queue-based
// reference model checked every cycle plus literal spot checks.
module tb_glb_wr_bank;

    localparam int W  = 256;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int D  = 256;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          ccuRst = 1'b0;
    logic          cfgVld = 1'b0;
    logic [AW-1:0] wrNum  = '0;
    logic [AW-1:0] wrAddr = '0;
    logic [W-1:0]  wrDat  = '0;
    logic          wrVld  = 1'b0;
    logic          crdy   = 1'b0;

    logic          rdy;
    logic          full;
    logic [W-1:0]  rdDat;
    logic          rdVld;
    logic          done;
    logic          err;

    int nCmp = 0;
    int nErr = 0;
    bit mdlOn = 0;

    always #5 clk = ~clk;

    glb_wr_bank #(
        .SRAM_WIDTH (W),
        .ADDR_WIDTH (AW),
        .DEPTH_WIDTH(DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .CCUGLB_Rst     (ccuRst),
        .CCUGLB_CfgVld  (cfgVld),
        .CCUGLB_WrNum   (wrNum),
        .ITFGLB_WrAddr  (wrAddr),
        .ITFGLB_WrDat   (wrDat),
        .ITFGLB_WrDatVld(wrVld),
        .GLBITF_WrDatRdy(rdy),
        .GLBITF_WrFull  (full),
        .GLBCOR_RdDat   (rdDat),
        .GLBCOR_RdDatVld(rdVld),
        .CORGLB_RdDatRdy(crdy),
        .GLBCCU_Done    (done),
        .GLBCCU_AddrErr (err)
    );

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mkWord(int tag, int i);
        return {32'(tag), 192'(i * 7 + 3), 32'(i)};
    endfunction

    // Reference model: bank content as an ordered queue; qi marks words
    // already prefetched toward the consumer (at most two, one per cycle,
    // never in the cycle the word was written).
    logic [W-1:0] qd[$];
    bit           qi[$];
    int           mWrCnt;
    int           mWrNum;
    int           mTot;
    bit           mErr;

    task automatic mdlClear();
        qd.delete();
        qi.delete();
        mWrCnt = 0;
        mWrNum = 0;
        mTot   = 0;
        mErr   = 0;
    endtask

    always @(negedge clk) begin
        bit           eRdy;
        bit           eVld;
        logic [W-1:0] eDat;
        int           nIss;
        int           j;
        if (mdlOn) begin
            eRdy = (qd.size() < D) && (mWrCnt < mWrNum);
            eVld = (qd.size() > 0) && qi[0];
            eDat = eVld ? qd[0] : '0;
            chk("rdy", rdy, eRdy);
            chk("full", full, !eRdy);
            chk("vld", rdVld, eVld);
            chk("dat", rdDat, eDat);
            chk("done", done, (mWrCnt == mWrNum) && (qd.size() == 0));
            chk("err", err, mErr);
            if (!rst_n || ccuRst) begin
                mdlClear();
            end else begin
                nIss = 0;
                j = -1;
                foreach (qi[k]) begin
                    if (qi[k]) nIss++;
                    else if (j < 0) j = k;
                end
                if (j >= 0 && nIss < 2) qi[j] = 1;
                if (eVld && crdy) begin
                    void'(qd.pop_front());
                    void'(qi.pop_front());
                end
                if (wrVld && eRdy) begin
                    qd.push_back(wrDat);
                    qi.push_back(1'b0);
                    if (wrAddr[DW-1:0] != mTot[DW-1:0]) mErr = 1;
                    mTot++;
                    mWrCnt++;
                end
                if (cfgVld) begin
                    mWrNum = int'(wrNum);
                    mWrCnt = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(int n);
        cfgVld = 1'b1;
        wrNum  = AW'(n);
        tick();
        cfgVld = 1'b0;
    endtask

    task automatic rstPulse();
        ccuRst = 1'b1;
        tick();
        ccuRst = 1'b0;
    endtask

    task automatic wrW(int a, logic [W-1:0] d);
        int n = 0;
        wrVld  = 1'b1;
        wrAddr = AW'(a);
        wrDat  = d;
        while (!rdy && n < 1000) begin
            tick();
            n++;
        end
        if (!rdy) begin
            chk("wr_timeout", rdy, 1);
            wrVld = 1'b0;
            return;
        end
        tick();
        wrVld = 1'b0;
    endtask

    initial begin
        int pops;
        mdlClear();
        #1 rst_n = 1'b0;
        mdlOn = 1;
        repeat (3) tick();
        rst_n = 1'b1;

        chk("rst_rdy", rdy, 0);
        chk("rst_full", full, 1);
        chk("rst_vld", rdVld, 0);
        chk("rst_dat", rdDat, 0);
        chk("rst_done", done, 1);
        chk("rst_err", err, 0);

        // Short transfer, streaming consumer: latency 2, no bubbles.
        cfg(4);
        crdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wrVld  = 1'b1;
            wrAddr = AW'(i);
            wrDat  = mkWord(1, i);
            chk("t1_rdy", rdy, 1);
            if (i >= 2) begin
                chk("t1_vld", rdVld, 1);
                chk("t1_dat", rdDat, mkWord(1, i - 2));
            end else begin
                chk("t1_vld0", rdVld, 0);
            end
            tick();
        end
        wrVld = 1'b0;
        chk("t1_full", full, 1);
        chk("t1_rdylo", rdy, 0);
        chk("t1_dat2", rdDat, mkWord(1, 2));
        tick();
        chk("t1_dat3", rdDat, mkWord(1, 3));
        chk("t1_notdone", done, 0);
        tick();
        chk("t1_vldend", rdVld, 0);
        chk("t1_done", done, 1);

        // Fill the whole bank, free one slot, write across the wrap.
        rstPulse();
        cfg(300);
        crdy = 1'b0;
        for (int i = 0; i < 256; i++) wrW(i, mkWord(2, i));
        chk("t2_full", full, 1);
        chk("t2_rdy", rdy, 0);
        chk("t2_head", rdDat, mkWord(2, 0));
        crdy = 1'b1;
        tick();
        crdy = 1'b0;
        chk("t2_rdyback", rdy, 1);
        wrW(256, mkWord(2, 256));
        chk("t2_noerr", err, 0);
        chk("t2_refull", full, 1);
        crdy = 1'b1;
        repeat (262) tick();
        crdy = 1'b0;
        chk("t2_drained", rdVld, 0);

        // Consumer toggling ready while 16 words stream in.
        rstPulse();
        cfg(16);
        pops = 0;
        fork
            begin
                for (int i = 0; i < 16; i++) wrW(i, mkWord(3, i));
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    crdy = c[0];
                    if (rdVld && crdy) pops++;
                    tick();
                end
                crdy = 1'b0;
            end
        join
        chk("t3_pops", pops, 16);
        chk("t3_vld", rdVld, 0);
        chk("t3_done", done, 1);

        // Address mismatch is sticky; data still in order.
        rstPulse();
        cfg(8);
        crdy = 1'b1;
        for (int i = 0; i < 3; i++) wrW(i, mkWord(4, i));
        chk("t4_noerr", err, 0);
        wrW(5, mkWord(4, 3));
        chk("t4_err", err, 1);
        wrW(4, mkWord(4, 4));
        repeat (6) tick();
        chk("t4_sticky", err, 1);
        chk("t4_vld", rdVld, 0);
        rstPulse();
        chk("t4_clr", err, 0);

        // Reconfigure in the same cycle as an accept.
        cfg(8);
        crdy = 1'b1;
        for (int i = 0; i < 3; i++) wrW(i, mkWord(5, i));
        wrVld  = 1'b1;
        wrAddr = AW'(3);
        wrDat  = mkWord(5, 3);
        cfgVld = 1'b1;
        wrNum  = AW'(2);
        chk("t5_rdy", rdy, 1);
        tick();
        wrVld  = 1'b0;
        cfgVld = 1'b0;
        chk("t5_rdyafter", rdy, 1);
        wrW(4, mkWord(5, 4));
        chk("t5_notfull", full, 0);
        wrW(5, mkWord(5, 5));
        chk("t5_full", full, 1);
        chk("t5_rdylo", rdy, 0);
        repeat (6) tick();
        chk("t5_done", done, 1);

        // Clear with occupancy 10 and a read being issued.
        rstPulse();
        cfg(20);
        crdy = 1'b0;
        for (int i = 0; i < 11; i++) wrW(i, mkWord(6, i));
        crdy = 1'b1;
        tick();
        crdy = 1'b0;
        ccuRst = 1'b1;
        chk("t6_vldpre", rdVld, 1);
        tick();
        ccuRst = 1'b0;
        chk("t6_vld", rdVld, 0);
        chk("t6_full", full, 1);
        chk("t6_done", done, 1);
        chk("t6_dat", rdDat, 0);
        cfg(4);
        crdy = 1'b1;
        wrW(0, mkWord(7, 0));
        chk("t6_lat1", rdVld, 0);
        tick();
        chk("t6_lat2", rdVld, 1);
        chk("t6_fresh", rdDat, mkWord(7, 0));
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, want finish before 200000");
        $fatal(1);
    end

endmodule
